acq_axis_packer: RTL and testbench
==================================

ACQ_AXIS_PACKER -- requirements
Module: acq_axis_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning output FIFO depth in 32-bit beats (power of 2, >=4).
REQ-002 SHALL have parameter SAMPLE_W, default 16, meaning ADC sample width; fixed at 16, two samples per beat.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  acquisition enable, sampled at frame boundaries only.
REQ-006 SHALL have port frame_len  input  16  frame length in beats; 0 treated as 1.
REQ-007 SHALL have port adc_data  input  16  ADC sample.
REQ-008 SHALL have port adc_valid  input  1  sample qualifier, no backpressure.
REQ-009 SHALL have port m_tdata  output  32  AXI4-Stream data, DW_BYTES=4.
REQ-010 SHALL have port m_tvalid  output  1  stream valid.
REQ-011 SHALL have port m_tready  input  1  stream ready from downstream (DMA).
REQ-012 SHALL have port m_tlast  output  1  last beat of frame.
REQ-013 SHALL have ports m_tkeep, m_tstrb  output  4 each  constant 4'hF.
REQ-014 SHALL have port ovf_cnt  output  16  dropped-beat counter, saturating at 16'hFFFF.
REQ-015 SHALL have port ovf_flag  output  1  sticky overflow flag.
REQ-016 SHALL have port ovf_clr  input  1  synchronous clear of ovf_cnt and ovf_flag.
REQ-017 SHALL have port busy  output  1  high when state is RUN or FIFO non-empty.

Function
REQ-018 SHALL implement FSM states IDLE and RUN.
REQ-019 IDLE -> RUN at an edge with en=1; frame_len captured into len_q at that edge; beat counter cleared; half-word flag cleared.
REQ-020 In IDLE, adc_valid SHALL be ignored.
REQ-021 In RUN, the first accepted sample SHALL go to tdata[15:0] and the second to tdata[31:16]; the beat SHALL be written to the FIFO at the edge accepting the second sample.
REQ-022 A written beat SHALL carry tlast=1 iff beat counter == len_q-1.
REQ-023 After a tlast beat is written (or dropped): en=1 -> stay in RUN, recapture frame_len, clear beat counter; en=0 -> IDLE.
REQ-024 Deasserting en mid-frame SHALL NOT truncate the frame.
REQ-025 The beat counter SHALL advance on every completed beat, whether written or dropped, so frames stay len_q beats long upstream of overflow.
REQ-026 A completed beat SHALL be dropped when the FIFO is full and no read happens in the same cycle (m_tvalid & m_tready). On a drop, ovf_cnt +1 (saturating) and ovf_flag SHALL be set.
REQ-027 ovf_clr coinciding with a drop SHALL result in ovf_cnt=1 and ovf_flag=1.
REQ-028 A write into a full FIFO with a simultaneous read SHALL be accepted; occupancy SHALL stay unchanged.
REQ-029 The FIFO SHALL be first-word-fall-through: m_tvalid = non-empty; m_tdata/m_tlast = head entry.
REQ-030 m_tvalid SHALL rise in the cycle after the write edge (1-cycle latency from second sample to output).
REQ-031 m_tdata/m_tlast SHALL be held stable while m_tvalid & !m_tready.
REQ-032 Pointers SHALL be log2(FIFO_DEPTH)+1 bits with wrap bit. Full = MSBs differ and LSBs equal; empty = pointers equal.

Reset
REQ-033 On reset_n low, the block SHALL asynchronously go to: state IDLE, pointers 0, m_tvalid=0, m_tlast=0, m_tdata=0, ovf_cnt=0, ovf_flag=0, busy=0, half-word flag and beat counter 0.
REQ-034 Reset mid-frame SHALL discard FIFO contents and any partial beat; the first frame after release SHALL start cleanly at beat 0.
REQ-035 Reset release SHALL be synchronous to clk on the deassert edge; no beat SHALL be written in the first cycle after release.

Verification
REQ-036 Basic frame: en=1, frame_len=4, m_tready=1, 8 samples 0x0001..0x0008 -> beats 0x00020001, 0x00040003, 0x00060005, 0x00080007; tlast only on 4th beat; first m_tvalid one cycle after sample 2.
REQ-037 Backpressure/overflow: FIFO_DEPTH=16, m_tready=0, 40 samples in one long frame -> 16 beats buffered, ovf_cnt=4, ovf_flag=1; on release, 16 beats drain in order; ovf_clr -> ovf_cnt=0, ovf_flag=0.
REQ-038 Full with simultaneous read: FIFO full, m_tready=1 in the same cycle as a beat completion -> no drop, ovf_cnt unchanged, occupancy stays 16.
REQ-039 en drop mid-frame: frame_len=3, en low after beat 1 -> beats 2 and 3 still produced with tlast on beat 3, then IDLE; later samples ignored; busy falls after drain.
REQ-040 frame_len=0 -> every beat has tlast=1; frame_len change mid-frame takes effect only at the next frame.
REQ-041 Async reset asserted between the two samples of a beat and mid-drain -> all outputs at reset values immediately; the next frame's first beat holds the first post-reset sample pair.

Source files
------------

// File: rtl/acq_axis_packer.sv
`default_nettype none
// ============================================================================
// acq_axis_packer: packs 16-bit ADC sample pairs into framed 32-bit AXI4-Stream
// beats through a first-word-fall-through FIFO with overflow accounting. rev 1.0
// ============================================================================
module acq_axis_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en,
    input  logic [15:0]           frame_len,
    input  logic [SAMPLE_W-1:0]   adc_data,
    input  logic                  adc_valid,
    output logic [2*SAMPLE_W-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [3:0]            m_tkeep,
    output logic [3:0]            m_tstrb,
    output logic [15:0]           ovf_cnt,
    output logic                  ovf_flag,
    input  logic                  ovf_clr,
    output logic                  busy
);

    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int BEAT_W = 2 * SAMPLE_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           beat_q, beat_d;
    logic                  half_q, half_d;
    logic [SAMPLE_W-1:0]   lo_q, lo_d;
    logic [AW:0]           wr_ptr_q, rd_ptr_q;
    logic [15:0]           ovf_cnt_q;
    logic                  ovf_flag_q;
    logic [BEAT_W:0]       mem_q [FIFO_DEPTH];

    logic                  w_empty, w_full, w_rd, w_done, w_last, w_drop, w_wr;
    logic [15:0]           w_len_eff;
    logic [BEAT_W:0]       w_head;

    assign w_empty   = (wr_ptr_q == rd_ptr_q);
    assign w_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_rd      = !w_empty && m_tready;
    assign w_done    = (state_q == RUN) && adc_valid && half_q;
    assign w_last    = (beat_q == len_q - 16'd1);
    // A read in the same cycle frees the slot, so only a blocked full FIFO drops.
    assign w_drop    = w_done && w_full && !w_rd;
    assign w_wr      = w_done && !w_drop;
    assign w_len_eff = (frame_len == 16'd0) ? 16'd1 : frame_len;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        half_d  = half_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    len_d   = w_len_eff;
                    beat_d  = 16'd0;
                    half_d  = 1'b0;
                end
            end
            RUN: begin
                if (adc_valid) begin
                    if (!half_q) begin
                        lo_d   = adc_data;
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        if (w_last) begin
                            beat_d = 16'd0;
                            if (en) begin
                                len_d = w_len_eff;
                            end else begin
                                state_d = IDLE;
                            end
                        end else begin
                            beat_d = beat_q + 16'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= 16'd1;
            beat_q  <= 16'd0;
            half_q  <= 1'b0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            half_q  <= half_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) mem_q[wr_ptr_q[AW-1:0]] <= {w_last, adc_data, lo_q};
    end

    // Clear wins over the old count but a coincident drop still registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q  <= 16'd0;
            ovf_flag_q <= 1'b0;
        end else if (ovf_clr) begin
            ovf_cnt_q  <= w_drop ? 16'd1 : 16'd0;
            ovf_flag_q <= w_drop;
        end else if (w_drop) begin
            ovf_cnt_q  <= (ovf_cnt_q == 16'hFFFF) ? ovf_cnt_q : ovf_cnt_q + 16'd1;
            ovf_flag_q <= 1'b1;
        end
    end

    // Head is masked while empty so stale memory never reaches the bus.
    assign w_head   = mem_q[rd_ptr_q[AW-1:0]];
    assign m_tvalid = !w_empty;
    assign m_tdata  = w_empty ? '0 : w_head[BEAT_W-1:0];
    assign m_tlast  = w_empty ? 1'b0 : w_head[BEAT_W];
    assign m_tkeep  = 4'hF;
    assign m_tstrb  = 4'hF;
    assign ovf_cnt  = ovf_cnt_q;
    assign ovf_flag = ovf_flag_q;
    assign busy     = (state_q == RUN) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_acq_axis_packer.sv
`default_nettype none
// ============================================================================
// tb_acq_axis_packer: directed self-checking bench for acq_axis_packer. rev 1.0
// ============================================================================
module tb_acq_axis_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic [15:0] frame_len;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [3:0]  m_tkeep;
    logic [3:0]  m_tstrb;
    logic [15:0] ovf_cnt;
    logic        ovf_flag;
    logic        ovf_clr;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    acq_axis_packer #(.FIFO_DEPTH(16), .SAMPLE_W(16)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .frame_len(frame_len),
        .adc_data (adc_data),
        .adc_valid(adc_valid),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tlast  (m_tlast),
        .m_tkeep  (m_tkeep),
        .m_tstrb  (m_tstrb),
        .ovf_cnt  (ovf_cnt),
        .ovf_flag (ovf_flag),
        .ovf_clr  (ovf_clr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [15:0] d);
        adc_valid = 1'b1;
        adc_data  = d;
        step();
        adc_valid = 1'b0;
    endtask

    function automatic logic [31:0] ovf_beat(input int k);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(16'h0100 + 2 * k);
        hi = 16'(16'h0100 + 2 * k + 1);
        return {hi, lo};
    endfunction

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        frame_len = 16'd0;
        adc_data  = 16'd0;
        adc_valid = 1'b0;
        m_tready  = 1'b0;
        ovf_clr   = 1'b0;
        #12;
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, m_tlast}, 32'd0);
        chk("rst_tdata",  m_tdata, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_ovfcnt", {16'd0, ovf_cnt}, 32'd0);
        chk("rst_ovfflg", {31'd0, ovf_flag}, 32'd0);
        chk("tkeep",      {28'd0, m_tkeep}, 32'hF);
        chk("tstrb",      {28'd0, m_tstrb}, 32'hF);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Samples in IDLE are ignored
        sample(16'hDEAD);
        sample(16'hBEEF);
        step();
        chk("idle_ignore", {31'd0, m_tvalid}, 32'd0);

        // Basic 4-beat frame
        en = 1'b1; frame_len = 16'd4; m_tready = 1'b1;
        step();
        en = 1'b0;
        sample(16'h0001);
        chk("b_lat_valid", {31'd0, m_tvalid}, 32'd0);
        sample(16'h0002);
        chk("b1_valid", {31'd0, m_tvalid}, 32'd1);
        chk("b1_data",  m_tdata, 32'h00020001);
        chk("b1_last",  {31'd0, m_tlast}, 32'd0);
        sample(16'h0003); sample(16'h0004);
        chk("b2_data",  m_tdata, 32'h00040003);
        chk("b2_last",  {31'd0, m_tlast}, 32'd0);
        sample(16'h0005); sample(16'h0006);
        chk("b3_data",  m_tdata, 32'h00060005);
        chk("b3_last",  {31'd0, m_tlast}, 32'd0);
        sample(16'h0007); sample(16'h0008);
        chk("b4_data",  m_tdata, 32'h00080007);
        chk("b4_last",  {31'd0, m_tlast}, 32'd1);
        chk("b4_busy",  {31'd0, busy}, 32'd1);
        step();
        chk("b_drained", {31'd0, m_tvalid}, 32'd0);
        chk("b_idle_busy", {31'd0, busy}, 32'd0);

        // Overflow: 40 samples, no ready -> 16 buffered, 4 dropped
        m_tready = 1'b0; en = 1'b1; frame_len = 16'd100;
        step();
        en = 1'b0;
        for (int i = 0; i < 40; i++) sample(16'(16'h0100 + i));
        chk("ovf_cnt",   {16'd0, ovf_cnt}, 32'd4);
        chk("ovf_flag",  {31'd0, ovf_flag}, 32'd1);
        chk("ovf_head",  m_tdata, ovf_beat(0));
        chk("ovf_hold",  m_tdata, ovf_beat(0));

        // Full FIFO with a read in the completing cycle: no drop
        sample(16'(16'h0100 + 40));
        m_tready = 1'b1;
        sample(16'(16'h0100 + 41));
        m_tready = 1'b0;
        chk("fr_ovfcnt", {16'd0, ovf_cnt}, 32'd4);
        chk("fr_head",   m_tdata, ovf_beat(1));

        m_tready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), m_tdata, (k < 15) ? ovf_beat(k + 1) : ovf_beat(20));
            step();
        end
        chk("drain_empty", {31'd0, m_tvalid}, 32'd0);
        m_tready = 1'b0;
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_cnt",  {16'd0, ovf_cnt}, 32'd0);
        chk("clr_flag", {31'd0, ovf_flag}, 32'd0);

        // Async reset between the two samples of a beat, with a beat pending
        sample(16'h0200); sample(16'h0201); sample(16'h0202);
        chk("prerst_valid", {31'd0, m_tvalid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, m_tvalid}, 32'd0);
        chk("arst_data",  m_tdata, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
        en = 1'b1; frame_len = 16'd2; m_tready = 1'b1;
        step();
        en = 1'b0;
        sample(16'hA001); sample(16'hA002);
        chk("pr1_data", m_tdata, 32'hA002A001);
        chk("pr1_last", {31'd0, m_tlast}, 32'd0);
        sample(16'hA003); sample(16'hA004);
        chk("pr2_data", m_tdata, 32'hA004A003);
        chk("pr2_last", {31'd0, m_tlast}, 32'd1);
        step();
        chk("pr_busy", {31'd0, busy}, 32'd0);

        // en dropped mid-frame: frame still completes
        en = 1'b1; frame_len = 16'd3;
        step();
        sample(16'h0011); sample(16'h0012);
        chk("ed1_data", m_tdata, 32'h00120011);
        en = 1'b0;
        sample(16'h0013); sample(16'h0014);
        chk("ed2_data", m_tdata, 32'h00140013);
        chk("ed2_last", {31'd0, m_tlast}, 32'd0);
        sample(16'h0015); sample(16'h0016);
        chk("ed3_data", m_tdata, 32'h00160015);
        chk("ed3_last", {31'd0, m_tlast}, 32'd1);
        step();
        sample(16'h0077); sample(16'h0078);
        chk("ed_ignore", {31'd0, m_tvalid}, 32'd0);
        chk("ed_busy",   {31'd0, busy}, 32'd0);

        // frame_len=0 acts as 1; mid-frame length change is deferred
        en = 1'b1; frame_len = 16'd0;
        step();
        sample(16'h0021); sample(16'h0022);
        chk("z1_data", m_tdata, 32'h00220021);
        chk("z1_last", {31'd0, m_tlast}, 32'd1);
        sample(16'h0023);
        frame_len = 16'd2;
        sample(16'h0024);
        chk("z2_last", {31'd0, m_tlast}, 32'd1);
        frame_len = 16'd0;
        sample(16'h0025); sample(16'h0026);
        chk("c1_data", m_tdata, 32'h00260025);
        chk("c1_last", {31'd0, m_tlast}, 32'd0);
        en = 1'b0;
        sample(16'h0027); sample(16'h0028);
        chk("c2_last", {31'd0, m_tlast}, 32'd1);
        step();
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
